// File: rtl/ula_sequencer_pkg.sv
// Shared definitions for the ULA command sequencer: FSM state encoding and
// datapath size defaults.
package ula_sequencer_pkg;

  localparam int unsigned N_DEFAULT = 8;
  localparam int unsigned A_DEFAULT = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/ula_seq_fsm.sv
// Sequencer control FSM: fixed five-step walk per accepted command, emitting
// the accept/capture/write-back strobes consumed by the top.
module ula_seq_fsm
  import ula_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  output logic cmd_ready,
  output logic busy,
  output logic done,
  output logic accept,
  output logic capture,
  output logic wb
);

  state_t state;
  state_t next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (cmd_valid) next = DECODE;
      DECODE:  next = EXEC;
      EXEC:    next = WB;
      WB:      next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    wb        = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
      end
      DECODE: busy = 1'b1;
      EXEC: begin
        busy    = 1'b1;
        capture = 1'b1;
      end
      WB: begin
        busy = 1'b1;
        wb   = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ula_sequencer.sv
// Multi-cycle control unit for the register bank / ULA datapath: accepts one
// command, drives reads, captures the ULA result and writes it back.
module ula_sequencer
  import ula_sequencer_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned A = A_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [A-1:0] cmd_rd,
  input  logic [A-1:0] cmd_rs1,
  input  logic [A-1:0] cmd_rs2,
  input  logic         cmd_use_imm,
  input  logic         cmd_nowb,
  output logic [A-1:0] ra1,
  output logic [A-1:0] ra2,
  output logic [A-1:0] wa3,
  output logic         we3,
  output logic [N-1:0] wd3,
  output logic         ula_src,
  output logic [2:0]   ula_control,
  input  logic [N-1:0] ula_result,
  input  logic         ula_z,
  output logic [N-1:0] result_q,
  output logic         z_q,
  output logic         busy,
  output logic         done,
  output logic [7:0]   op_count
);

  typedef struct packed {
    logic [2:0]   op;
    logic [A-1:0] rd;
    logic [A-1:0] rs1;
    logic [A-1:0] rs2;
    logic         use_imm;
    logic         nowb;
  } cmd_t;

  cmd_t cmd_q;
  logic accept;
  logic capture;
  logic wb;

  ula_seq_fsm u_fsm (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .busy      (busy),
    .done      (done),
    .accept    (accept),
    .capture   (capture),
    .wb        (wb)
  );

  // The command register doubles as the registered read/mux/op drive; clearing
  // it on leaving DONE returns those outputs to zero in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_q <= '0;
    end else if (accept) begin
      cmd_q <= '{op: cmd_op, rd: cmd_rd, rs1: cmd_rs1, rs2: cmd_rs2,
                 use_imm: cmd_use_imm, nowb: cmd_nowb};
    end else if (done) begin
      cmd_q <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= '0;
      z_q      <= 1'b0;
    end else if (capture) begin
      result_q <= ula_result;
      z_q      <= ula_z;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      op_count <= '0;
    else if (done) op_count <= op_count + 8'd1;
  end

  always_comb begin
    ra1         = cmd_q.rs1;
    ra2         = cmd_q.rs2;
    ula_src     = cmd_q.use_imm;
    ula_control = cmd_q.op;
    we3         = wb & ~cmd_q.nowb;
    wa3         = wb ? cmd_q.rd : '0;
    wd3         = wb ? result_q : '0;
  end

endmodule

// File: doc/ula_sequencer.md
Name: ula_sequencer

Overview:
- Multi-cycle control unit for the register-bank / ULA datapath.
- Accepts one ALU command at a time through a valid/ready handshake and drives the datapath in order: register read addresses, ULASrc mux select and ULAControl, result capture, write-back to wd3/wa3/we3.
- Sits between a command source (switch decoder or, later, an instruction fetch unit) and the registrars_bank / mux_2x1 / ULA trio.
- Latched result, Z flag and operation counter feed the LCD/HEX display path.

Parameters:
N, 8, datapath width (register, immediate and result width)
A, 3, register address width (2**A registers)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  3  ULAControl code for this command
cmd_rd  input  A  destination register
cmd_rs1  input  A  source A register
cmd_rs2  input  A  source B register
cmd_use_imm  input  1  1 = SrcB from immediate path
cmd_nowb  input  1  1 = evaluate and update Z only, no write-back
ra1  output  A  bank read address 1
ra2  output  A  bank read address 2
wa3  output  A  bank write address
we3  output  1  bank write enable
wd3  output  N  bank write data
ula_src  output  1  SrcB mux select
ula_control  output  3  ULA operation
ula_result  input  N  ULA result, combinational from current ra1/ra2/ula_src/ula_control
ula_z  input  1  ULA zero flag, combinational
result_q  output  N  last captured result
z_q  output  1  last captured Z
busy  output  1  command in progress
done  output  1  one-cycle pulse at command completion
op_count  output  8  completed-command counter

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0 except cmd_ready=1. The command register clears. A reset mid-command aborts it and never pulses we3.
- States: IDLE -> DECODE -> EXEC -> WB -> DONE -> IDLE. No other transitions.
- IDLE: cmd_ready=1, busy=0. On cmd_valid=1 at a clock edge, latch all cmd_* fields and go to DECODE. cmd_valid=0 stays in IDLE.
- DECODE: ra1=rs1, ra2=rs2, ula_src=use_imm and ula_control=op, all registered. These hold unchanged through EXEC, WB and DONE, then return to 0 in IDLE.
- EXEC: capture ula_result into result_q and ula_z into z_q on the exiting edge.
- WB: wa3=rd, wd3=result_q, we3=1 for exactly this one cycle when nowb=0. When nowb=1, we3 stays 0 and result_q/z_q still update.
- DONE: done=1 for one cycle. op_count increments on the exiting edge and wraps 255->0.
- cmd_ready=1 only in IDLE. cmd_valid in any other state is ignored, with no queuing. Fields are sampled only at acceptance; later changes to cmd_* have no effect.
- busy=1 in DECODE, EXEC, WB and DONE.
- Latency: command accepted at edge k -> we3 high during cycle k+3 -> done high during cycle k+4 -> next acceptance possible at edge k+5. Back-to-back throughput is 1 command per 5 cycles.
- rd equal to rs1 or rs2: the write lands after capture, so the read uses the old value. The next command sees the new value.
- result_q and z_q persist across IDLE until the next EXEC or reset.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, DECODE=1, EXEC=2, WB=3, DONE=4; 3 bits)
  - the N and A defaults
- The package must not hold ULAControl opcode constants; those stay owned by the ULA.
- One sub-module, ula_seq_fsm: state register plus next-state/output decode.
- The top holds the command and capture registers and op_count.

Test Plan:
- Reset: assert rst=0 mid-stream -> all outputs 0, cmd_ready=1, op_count=0 immediately, asynchronously without a clock edge.
- Register-register command: bench bank with R1=8'h05, R2=8'h03, bench ULA op 3'b010 = add. Issue rs1=1, rs2=2, rd=4, op=010, use_imm=0 -> we3=1 only at cycle k+3 with wa3=4, wd3=8'h08; done at k+4; op_count=1; z_q=0.
- Immediate path: use_imm=1, bench ULA SrcB=8'h07, subtract with R1=8'h07 -> ula_src=1 from DECODE to DONE, result_q=0, z_q=1, write of 0 to rd.
- No write-back: nowb=1 -> we3 never asserted across the whole command; z_q and result_q still update; done pulses.
- Busy ignore: hold cmd_valid=1 continuously with changing fields -> commands accepted only at edges k, k+5, k+10; each uses the fields present at its own acceptance edge.
- Counter wrap and abort: 256 commands -> op_count=0. Reset asserted during WB -> we3 drops at once, op_count unchanged, state=IDLE.
